hd_encoder: RTL and testbench
=============================

# hd_encoder

Transmit-side Hamming(7,4) encoder for the HD datapath. Takes two signed 4-bit operands and a 2-bit operation code, forms two Hamming(7,4) codewords, and hides the operation code by injecting exactly one single-bit error per codeword. The received (flipped) value of that bit equals the matching opt bit. The block feeds the HD decoder/calculator across a valid/ready link and is a multi-cycle FSM that searches for a suitable error position.

## Interface
- PTR_ROTATE, 1, 1: the search start pointer advances per transaction; 0: the search always starts at bit 0.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- data_word1  input  4  operand w1, signed, two's complement.
- data_word2  input  4  operand w2, signed.
- opt  input  2  operation code; opt[1] is carried by code_word1, opt[0] by code_word2.
- code_word1  output  7  encoded w1 with one injected error; registered.
- code_word2  output  7  encoded w2 with one injected error; registered.
- out_valid  output  1  codewords valid.
- out_ready  input  1  downstream accepts.
- err  output  1  transaction was unencodable; the codewords are emitted clean.

## Operation
- Codeword bit map: [6]=p1, [5]=p2, [4]=p3, [3:0]=d[3:0].
  - p1 = d3^d2^d1.
  - p2 = d3^d2^d0.
  - p3 = d3^d1^d0.
- Injection rule:
  - For each word, flip one bit whose original value is the inverse of its opt bit.
  - After the flip, the received bit value equals the opt bit.
  - Per word, target = ~opt[1] for word1 and ~opt[0] for word2.
- Unencodable cases:
  - Codeword 0000000 (d=0000) with target 1.
  - Codeword 1111111 (d=1111) with target 0.
  - Either word unencodable: err=1, both codewords output uncorrupted, no search.
- Start pointer ptr:
  - 3 bits, range 0..6, reset 0.
  - On every accepted transaction: sptr<=ptr; ptr<=(ptr==6)?0:ptr+1 when PTR_ROTATE=1.
  - Accepted includes err transactions.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture the operands and opt, go to ENC.
  - ENC: compute both codewords. If unencodable, go to DONE with err=1. Else set idx=sptr and go to SRCH1.
  - SRCH1: examine cw1[idx] once per cycle.
    - Match: flip the bit, set idx=sptr, go to SRCH2.
    - No match: idx wraps 6→0.
  - SRCH2: same search on cw2. On match, flip and go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE.
- A search never exceeds 7 cycles, because the encodable check guarantees a match. The index sequence is sptr, sptr+1, … mod 7.

## Timing
- Reset values: code_word1=0, code_word2=0, out_valid=0, err=0, ptr=0, state=IDLE, so in_ready=1.
- Acceptance is at edge E0. Define k1 and k2 as 1 + the distance (mod 7) from sptr to the first matching index in cw1 and cw2 respectively.
- Latency:
  - Normal: out_valid rises after edge E(1+k1+k2), so minimum 3 and maximum 15 edges.
  - err path: out_valid rises after E1.
- in_ready is low from E0 until the DONE handshake edge. Back-to-back: in_ready is high the cycle after out_valid&&out_ready.
- Backpressure: in DONE with out_ready=0, code_word1, code_word2, out_valid and err hold indefinitely.
- err clears on the next acceptance.
- rst mid-operation, in any state: immediate return to reset values. The in-flight transaction is discarded and ptr returns to 0.

## Structure
- Package hd_pkg holds:
  - State enum {IDLE, ENC, SRCH1, SRCH2, DONE}.
  - Bit-index constants P1=6, P2=5, P3=4.
  - POS_MAX=6.
- Sub-module hd_parity: combinational 4→7 codeword generator per the bit map, instantiated twice.
- Search index, sptr and ptr stay in hd_encoder.

## Test plan
- Reset, ptr=0; w1=0011, w2=0101, opt=00 -> cw1=1100011 and cw2=1010101 before injection; bit0 flipped in both -> code_word1=1100010, code_word2=1010100, err=0, latency 3. The decoder then yields 11.
- Next transaction (ptr=1): w1=0011, w2=0101, opt=11 -> code_word1=1100111 (k1=2), code_word2=1010111 (k2=1), latency 4. The decoder then yields 13.
- w1=0000, opt=00 (target 1 on all-zero codeword) -> err=1, code_word1=0000000, code_word2 clean, latency 1; ptr still advances.
- w2=1111, opt=01 (target 0 on 1111111) -> err=1, code_word2=1111111 clean.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then raise out_ready -> in_ready=1 the next cycle.
- Assert rst during SRCH1 -> out_valid=0, codewords 0, in_ready=1, ptr=0. A following transaction behaves as the first test.

Source files
------------

// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared types, constants and helpers for the HD Hamming(7,4) encoder
//
// Purpose : FSM state encoding, codeword bit positions, search-pointer range
//           and small helper functions used by hd_encoder and hd_parity.
// Ports   : none (package).
package hd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENC   = 3'd1,
        SRCH1 = 3'd2,
        SRCH2 = 3'd3,
        DONE  = 3'd4
    } hd_state_t;

    localparam int P1 = 6;
    localparam int P2 = 5;
    localparam int P3 = 4;

    localparam logic [2:0] POS_MAX = 3'd6;

    // Next bit position in the circular 0..POS_MAX search order.
    function automatic logic [2:0] next_pos(input logic [2:0] pos);
        return (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
    endfunction

    // A codeword has no bit equal to the target only when it is all-zero
    // (target 1) or all-one (target 0); both follow from the data nibble alone.
    function automatic logic unencodable(input logic [3:0] d, input logic target);
        return (target && (d == 4'b0000)) || (!target && (d == 4'b1111));
    endfunction

endpackage

// File: rtl/hd_parity.sv
// rtl/hd_parity.sv - combinational Hamming(7,4) codeword generator
//
// Purpose : maps a 4-bit data nibble to a 7-bit codeword {p1,p2,p3,d[3:0]}.
// Ports   : d  - data nibble in
//           cw - codeword out, [6]=p1 [5]=p2 [4]=p3 [3:0]=d
module hd_parity
    import hd_pkg::*;
(
    input  logic [3:0] d,
    output logic [6:0] cw
);

    always_comb begin
        cw[3:0] = d;
        cw[P1]  = d[3] ^ d[2] ^ d[1];
        cw[P2]  = d[3] ^ d[2] ^ d[0];
        cw[P3]  = d[3] ^ d[1] ^ d[0];
    end

endmodule

// File: rtl/hd_encoder.sv
// rtl/hd_encoder.sv - Hamming(7,4) encoder hiding a 2-bit opcode as injected bit errors
//
// Purpose : accepts two signed nibbles and an opcode, encodes each nibble, then
//           searches each codeword (from a rotating start pointer) for a bit whose
//           value is ~opt bit and flips it, so the received bit carries the opcode.
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready, data_word1, data_word2, opt - input handshake
//           code_word1, code_word2, err, out_valid/out_ready - output handshake
module hd_encoder
    import hd_pkg::*;
#(
    parameter bit PTR_ROTATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] data_word1,
    input  logic [3:0] data_word2,
    input  logic [1:0] opt,
    output logic [6:0] code_word1,
    output logic [6:0] code_word2,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    hd_state_t  state_q, state_d;
    logic [3:0] w1_q, w2_q;
    logic [1:0] opt_q;
    logic [2:0] ptr, sptr, idx;
    logic [6:0] cw1_enc, cw2_enc;
    logic       target1, target2;
    logic       unenc;
    logic       accept;

    hd_parity u_parity1 (.d(w1_q), .cw(cw1_enc));
    hd_parity u_parity2 (.d(w2_q), .cw(cw2_enc));

    // The bit we flip must currently hold the inverse of the opcode bit.
    assign target1 = ~opt_q[1];
    assign target2 = ~opt_q[0];
    assign unenc   = unencodable(w1_q, target1) || unencodable(w2_q, target2);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready && in_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ENC;
            ENC:     state_d = unenc ? DONE : SRCH1;
            SRCH1:   if (code_word1[idx] == target1) state_d = SRCH2;
            SRCH2:   if (code_word2[idx] == target2) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1_q       <= '0;
            w2_q       <= '0;
            opt_q      <= '0;
            ptr        <= '0;
            sptr       <= '0;
            idx        <= '0;
            code_word1 <= '0;
            code_word2 <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                w1_q  <= data_word1;
                w2_q  <= data_word2;
                opt_q <= opt;
                err   <= 1'b0;
                sptr  <= ptr;
                if (PTR_ROTATE) begin
                    ptr <= next_pos(ptr);
                end
            end
            case (state_q)
                ENC: begin
                    code_word1 <= cw1_enc;
                    code_word2 <= cw2_enc;
                    err        <= unenc;
                    idx        <= sptr;
                end
                SRCH1: begin
                    if (code_word1[idx] == target1) begin
                        code_word1[idx] <= ~code_word1[idx];
                        idx             <= sptr;
                    end else begin
                        idx <= next_pos(idx);
                    end
                end
                SRCH2: begin
                    if (code_word2[idx] == target2) begin
                        code_word2[idx] <= ~code_word2[idx];
                    end else begin
                        idx <= next_pos(idx);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hd_encoder.sv
// tb/tb_hd_encoder.sv - directed self-checking bench for hd_encoder
module tb_hd_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] data_word1 = '0;
    logic [3:0] data_word2 = '0;
    logic [1:0] opt = '0;
    logic [6:0] code_word1, code_word2;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    hd_encoder #(.PTR_ROTATE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_word1 (data_word1),
        .data_word2 (data_word2),
        .opt        (opt),
        .code_word1 (code_word1),
        .code_word2 (code_word2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: accept at E0, count edges until out_valid, check outputs,
    // optionally stall hold cycles in DONE, then complete the handshake.
    task automatic run_tx(input string tag, input logic [3:0] w1, input logic [3:0] w2,
                          input logic [1:0] op, input logic [6:0] exp_cw1,
                          input logic [6:0] exp_cw2, input logic exp_err,
                          input int exp_lat, input int hold);
        int  lat;
        logic stable;
        lat = 0;
        @(negedge clk);
        data_word1 = w1;
        data_word2 = w2;
        opt        = op;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 1'b0);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_cw1"}, code_word1, exp_cw1);
        check({tag, "_cw2"}, code_word2, exp_cw2);
        check({tag, "_err"}, err, exp_err);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!(out_valid && !in_ready && code_word1 == exp_cw1 &&
                      code_word2 == exp_cw2 && err == exp_err)) stable = 1'b0;
            end
            check({tag, "_hold"}, stable, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_ready_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        #3;
        check("reset_cw1", code_word1, 7'd0);
        check("reset_cw2", code_word2, 7'd0);
        check("reset_vld_err_rdy", {out_valid, err, in_ready}, 3'b001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // sptr 0..4
        run_tx("t1_opt00",    4'b0011, 4'b0101, 2'b00, 7'b1100010, 7'b1010100, 1'b0, 3, 0);
        run_tx("t2_opt11",    4'b0011, 4'b0101, 2'b11, 7'b1100111, 7'b1010111, 1'b0, 4, 0);
        run_tx("t3_err_zero", 4'b0000, 4'b0101, 2'b00, 7'b0000000, 7'b1010101, 1'b1, 1, 0);
        run_tx("t4_err_ones", 4'b0011, 4'b1111, 2'b01, 7'b1100011, 7'b1111111, 1'b1, 1, 0);
        run_tx("t5_backpr",   4'b0011, 4'b0101, 2'b00, 7'b1000011, 7'b1000101, 1'b0, 4, 10);

        // sptr 5: reset while in SRCH1
        @(negedge clk);
        data_word1 = 4'b0011;
        data_word2 = 4'b0101;
        opt        = 2'b00;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_cw1", code_word1, 7'd0);
        check("midrst_cw2", code_word2, 7'd0);
        check("midrst_vld_rdy", {out_valid, err, in_ready}, 3'b001);
        @(negedge clk);
        rst = 1'b0;

        // ptr back at 0: same result as the first transaction
        run_tx("r1_opt00",    4'b0011, 4'b0101, 2'b00, 7'b1100010, 7'b1010100, 1'b0, 3, 0);
        run_tx("r2_opt11",    4'b0011, 4'b0101, 2'b11, 7'b1100111, 7'b1010111, 1'b0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            run_tx("adv_err", 4'b0000, 4'b0000, 2'b00, 7'b0000000, 7'b0000000, 1'b1, 1, 0);
        end
        // sptr 6, then wrap to 0
        run_tx("p6_opt00",    4'b0011, 4'b0101, 2'b00, 7'b0100011, 7'b0010101, 1'b0, 3, 0);
        run_tx("wrap_opt11",  4'b0011, 4'b0101, 2'b11, 7'b1100111, 7'b1010111, 1'b0, 6, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
